// File: rtl/cvd_sched_pkg.sv
// Shared types for the sprite update scheduler: FIFO word layout and FSM states.
package cvd_sched_pkg;

  localparam int POS_W      = 11;
  localparam int N_OBJ      = 4;
  localparam int ID_W       = $clog2(N_OBJ);
  localparam int FIFO_DEPTH = 8;
  localparam int FCNT_W     = 16;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             en;
  } obj_upd_t;

  localparam int UPD_W = $bits(obj_upd_t);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_DONE   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle shared by the draw pipeline; consumers take the vga_in view.
interface vga_if;
  import cvd_sched_pkg::*;

  logic [POS_W-1:0] hcount;
  logic [POS_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;

  modport vga_in (input hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/upd_fifo.sv
// Synchronous FIFO without output register; extra wrap bit on each pointer
// distinguishes full from empty.
module upd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/sprite_upd_sched.sv
// Queues object position/visibility updates and commits them to shadow
// registers only during vertical blanking, so draw stages see stable positions.
module sprite_upd_sched #(
  parameter int N_OBJ      = cvd_sched_pkg::N_OBJ,
  parameter int FIFO_DEPTH = cvd_sched_pkg::FIFO_DEPTH,
  parameter int POS_W      = cvd_sched_pkg::POS_W,
  parameter int FCNT_W     = cvd_sched_pkg::FCNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vga_if.vga_in                     vga_in,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [$clog2(N_OBJ)-1:0]  upd_id,
  input  logic [POS_W-1:0]          upd_x,
  input  logic [POS_W-1:0]          upd_y,
  input  logic                      upd_en,
  output logic [N_OBJ*POS_W-1:0]    obj_x,
  output logic [N_OBJ*POS_W-1:0]    obj_y,
  output logic [N_OBJ-1:0]          obj_en,
  output logic                      frame_tick,
  output logic [FCNT_W-1:0]         frame_cnt,
  output logic                      late,
  input  logic                      clr_late
);
  import cvd_sched_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(N_OBJ);

  obj_upd_t     fifo_din, fifo_dout;
  logic         fifo_full, fifo_empty, push, pop;
  logic [AW:0]  fifo_count;

  sched_state_t      state_q, state_d;
  logic [AW:0]       left_q, left_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              late_q, late_d;
  logic              vblnk_q, rise;
  logic [POS_W-1:0]  x_q [N_OBJ];
  logic [POS_W-1:0]  x_d [N_OBJ];
  logic [POS_W-1:0]  y_q [N_OBJ];
  logic [POS_W-1:0]  y_d [N_OBJ];
  logic [N_OBJ-1:0]  en_q, en_d;

  // Only vblnk drives the scheduler; the rest of the timing bundle is intentionally ignored.
  logic unused_timing;
  assign unused_timing = ^{vga_in.hcount, vga_in.vcount, vga_in.hsync,
                           vga_in.vsync, vga_in.hblnk};

  assign upd_ready = !fifo_full;
  assign push      = upd_valid && upd_ready;
  assign fifo_din  = '{id: upd_id, x: upd_x, y: upd_y, en: upd_en};
  assign rise      = vga_in.vblnk && !vblnk_q;

  upd_fifo #(.W(UPD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    fcnt_d  = fcnt_q;
    late_d  = clr_late ? 1'b0 : late_q;
    pop     = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    en_d    = en_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          left_d  = fifo_count;
          fcnt_d  = fcnt_q + FCNT_W'(1);
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (left_q == '0) begin
          state_d = S_DONE;
        end else if (!vga_in.vblnk) begin
          late_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          pop    = 1'b1;
          left_d = left_q - (AW+1)'(1);
          // Ids with no matching slot are consumed without writing anything.
          for (int i = 0; i < N_OBJ; i++) begin
            if (fifo_dout.id == IW'(i)) begin
              x_d[i]  = fifo_dout.x;
              y_d[i]  = fifo_dout.y;
              en_d[i] = fifo_dout.en;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      left_q  <= '0;
      fcnt_q  <= '0;
      late_q  <= 1'b0;
      vblnk_q <= 1'b1;
      en_q    <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      fcnt_q  <= fcnt_d;
      late_q  <= late_d;
      vblnk_q <= vga_in.vblnk;
      en_q    <= en_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
    assign obj_x[g*POS_W +: POS_W] = x_q[g];
    assign obj_y[g*POS_W +: POS_W] = y_q[g];
  end

  assign obj_en     = en_q;
  assign frame_tick = (state_q == S_DONE);
  assign frame_cnt  = fcnt_q;
  assign late       = late_q;

endmodule
